gf_sum_sched: RTL and testbench
===============================

// Module: gf_sum_sched
// PURPOSE
//  Round-robin scheduler sharing one combinational GF(2^m) XOR-reduction tree (tree_w_xor) among NUM_REQ requesters.
//  Each job is BEATS beats of PARALLELISM symbols. The block steers the granted requester's beats into the shared tree.
//  It XOR-accumulates the tree outputs and returns one BIT_WIDTH sum per job over a valid/ready result port.
//  Sits between syndrome/Chien partial-sum producers and the single shared tree instance.
// PARAMETERS
//  BIT_WIDTH    10  symbol width, GF(2^BIT_WIDTH)
//  PARALLELISM  16  symbols per beat (tree input count)
//  NUM_REQ      4   requesters, >=1
//  BEATS        4   beats per job, >=1
//  ID_W (local) clog2(NUM_REQ), min 1
//  CNT_W (local) clog2(BEATS), min 1
// PORTS
//  clk        in   1                          clock, rising edge
//  rstn       in   1                          async active-low reset
//  req_valid  in   NUM_REQ                    per-requester beat valid
//  req_ready  out  NUM_REQ                    per-requester beat accept, one-hot or zero
//  req_data   in   NUM_REQ*PARALLELISM*BIT_WIDTH  requester r at [r*P*W +: P*W]
//  tree_in    out  PARALLELISM*BIT_WIDTH      to shared tree input
//  tree_out   in   BIT_WIDTH                  from shared tree output, combinational
//  res_valid  out  1                          job sum valid
//  res_ready  in   1                          result consumer accept
//  res_data   out  BIT_WIDTH                  XOR of all beats' tree outputs
//  res_id     out  ID_W                       requester index of res_data
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, acc=0.
//    Outputs during and after reset: req_ready=0, res_valid=0, res_data=0, res_id=0, tree_in=0.
//  FSM IDLE/RUN/DONE (+FLUSH with macro).
//  IDLE: if |req_valid -> grant = first valid index at or after rr_ptr, modulo NUM_REQ with wrap; enter RUN.
//    No beat is accepted in IDLE (1-cycle arbitration bubble).
//  RUN: req_ready[grant]=1 (combinational); all other req_ready bits 0.
//    tree_in = req_data slice of grant; tree_in = 0 in all other states.
//    Handshake = req_valid[grant] & req_ready[grant]:
//      acc <= (beat_cnt==0) ? tree_out : acc ^ tree_out; beat_cnt++.
//    No handshake: stall; acc and beat_cnt hold. There is no timeout or abort.
//    Other requesters' valid is ignored while a job is locked.
//    Handshake with beat_cnt==BEATS-1 -> DONE, beat_cnt<=0.
//  DONE: res_valid=1, res_data=acc, res_id=grant; all three stable until res_ready.
//    res_valid&res_ready -> rr_ptr <= (grant==NUM_REQ-1) ? 0 : grant+1; go to IDLE.
//  Latency (no macro, no stalls): first beat accepted 1 cycle after valid is seen in IDLE.
//    res_valid asserts the cycle after the last beat. Job throughput is BEATS+2 cycles.
//  Fairness: a requester waits at most NUM_REQ-1 jobs before being granted.
//  BEATS=1: RUN lasts one handshake. NUM_REQ=1: rr_ptr stays 0.
//  Reset mid-job: the job is discarded; no partial result is emitted.
// CONFIGURATION
//  GF_SUM_SCHED_PIPE_EN defined: tree_out is registered (tree_q) on each handshake; acc updates from tree_q one cycle later.
//    Last handshake -> FLUSH (1 cycle, folds tree_q) -> DONE. Adds +1 cycle result latency; throughput BEATS+3.
//    Use when tree depth limits fmax.
//  Not defined: no FLUSH state; tree_out is accumulated in the same cycle, as described above.
// TESTING  (W=10, P=4, NUM_REQ=4, BEATS=2 unless noted)
//  1 Reset: rstn=0 mid-RUN, then release -> req_ready=0, res_valid=0, next grant is to req0 when all requesters are valid.
//  2 Single job: req1 beats {1,2,4,8},{3,0,0,0} -> res_data=0x00C, res_id=1, res_valid on the cycle after beat 2 (no macro).
//  3 Round-robin: all 4 valid continuously -> res_id sequence 0,1,2,3,0; each job takes 4 cycles with res_ready=1.
//  4 Stalls: req2 drops valid for 3 cycles between beats; res_ready held 0 for 5 cycles.
//    -> sum unchanged, res_data/res_id stable, req_ready=0 for all in DONE.
//  5 Symbol values: beats {0x3FF,0x3FF,0x155,0},{0x2AA,0,0,0} -> res_data=0x3FF; BEATS=1 variant returns 0x155.
//  6 With GF_SUM_SCHED_PIPE_EN: repeat test 2 -> same res_data, res_valid exactly 1 cycle later than in test 2.

Source files
------------

// File: rtl/gf_sum_sched.sv
`default_nettype none
// ============================================================================
//  Module      : gf_sum_sched
//  Description : Round-robin scheduler that time-shares one combinational
//                GF(2^m) XOR-reduction tree among NUM_REQ requesters. Each
//                job is BEATS beats of PARALLELISM symbols. The tree outputs
//                of all beats are XOR-accumulated, and one BIT_WIDTH sum per
//                job is returned on a valid/ready result port.
//  Option      : GF_SUM_SCHED_PIPE_EN -- register the tree output before
//                accumulating. This adds a one-cycle FLUSH state per job.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf_sum_sched #(
    parameter  int BIT_WIDTH   = 10,
    parameter  int PARALLELISM = 16,
    parameter  int NUM_REQ     = 4,
    parameter  int BEATS       = 4,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*PARALLELISM*BIT_WIDTH-1:0]  req_data,
    output logic [PARALLELISM*BIT_WIDTH-1:0]          tree_in,
    input  logic [BIT_WIDTH-1:0]                      tree_out,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [BIT_WIDTH-1:0]                      res_data,
    output logic [ID_W-1:0]                           res_id
);

    localparam int              SLICE_W     = PARALLELISM * BIT_WIDTH;
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ID_W-1:0]  c_LAST_ID   = ID_W'(NUM_REQ - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
`ifdef GF_SUM_SCHED_PIPE_EN
    localparam logic [1:0] c_FLUSH = 2'd3;
`endif

    logic [1:0]           state_q,    state_d;
    logic [ID_W-1:0]      rr_ptr_q,   rr_ptr_d;
    logic [ID_W-1:0]      grant_q,    grant_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [BIT_WIDTH-1:0] acc_q,      acc_d;
`ifdef GF_SUM_SCHED_PIPE_EN
    // Registered tree output plus "holds an unfolded beat" and "was beat 0"
    logic [BIT_WIDTH-1:0] tree_q,     tree_d;
    logic                 tq_vld_q,   tq_vld_d;
    logic                 tq_first_q, tq_first_d;
`endif

    logic [ID_W-1:0]      hi_idx;
    logic [ID_W-1:0]      lo_idx;
    logic                 hi_found;
    logic [ID_W-1:0]      pick_idx;
    logic                 hs;
    logic                 last_beat;

    // Round-robin pick: lowest valid index at/after rr_ptr, else lowest valid overall (wrap)
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                lo_idx = ID_W'(j);
                if (ID_W'(j) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(j);
                end
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
    end

    assign hs        = (state_q == c_RUN) && req_valid[grant_q];
    assign last_beat = (beat_cnt_q == c_LAST_BEAT);

    // State and datapath registers; reset discards any job in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= c_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            acc_q      <= '0;
`ifdef GF_SUM_SCHED_PIPE_EN
            tree_q     <= '0;
            tq_vld_q   <= 1'b0;
            tq_first_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
`ifdef GF_SUM_SCHED_PIPE_EN
            tree_q     <= tree_d;
            tq_vld_q   <= tq_vld_d;
            tq_first_q <= tq_first_d;
`endif
        end
    end

    // Next-state logic: arbitration, beat counting, accumulation, result release
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        acc_d      = acc_q;
`ifdef GF_SUM_SCHED_PIPE_EN
        tree_d     = tree_q;
        tq_vld_d   = 1'b0;
        tq_first_d = tq_first_q;
        // Fold the beat captured on the previous handshake
        if (tq_vld_q) begin
            acc_d = tq_first_q ? tree_q : (acc_q ^ tree_q);
        end
`endif
        case (state_q)
            c_IDLE: begin
                // One-cycle arbitration bubble: no beat is taken here
                if (|req_valid) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = c_RUN;
                end
            end
            c_RUN: begin
                if (hs) begin
`ifdef GF_SUM_SCHED_PIPE_EN
                    tree_d     = tree_out;
                    tq_vld_d   = 1'b1;
                    tq_first_d = (beat_cnt_q == '0);
`else
                    acc_d = (beat_cnt_q == '0) ? tree_out : (acc_q ^ tree_out);
`endif
                    if (last_beat) begin
                        beat_cnt_d = '0;
`ifdef GF_SUM_SCHED_PIPE_EN
                        state_d    = c_FLUSH;
`else
                        state_d    = c_DONE;
`endif
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
`ifdef GF_SUM_SCHED_PIPE_EN
            c_FLUSH: begin
                state_d = c_DONE;
            end
`endif
            c_DONE: begin
                if (res_ready) begin
                    rr_ptr_d = (grant_q == c_LAST_ID) ? '0 : (grant_q + 1'b1);
                    state_d  = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Outputs: steer the granted slice into the tree during RUN, present the sum in DONE
    always_comb begin
        req_ready = '0;
        tree_in   = '0;
        res_valid = 1'b0;
        res_data  = '0;
        res_id    = '0;
        if (state_q == c_RUN) begin
            req_ready[grant_q] = 1'b1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (grant_q == ID_W'(r)) begin
                    tree_in = req_data[r*SLICE_W +: SLICE_W];
                end
            end
        end
        if (state_q == c_DONE) begin
            res_valid = 1'b1;
            res_data  = acc_q;
            res_id    = grant_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gf_sum_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf_sum_sched
//  Description : Self-checking bench for gf_sum_sched (W=10, P=4, 4 req,
//                2 beats) plus a BEATS=1 instance. Each job's expected sum
//                is the XOR of all of its symbols. Expected grants follow
//                the round-robin rule applied to the valid vector seen in
//                IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf_sum_sched;

    localparam int W  = 10;
    localparam int P  = 4;
    localparam int N  = 4;
    localparam int B  = 2;
    localparam int SW = P * W;
`ifdef GF_SUM_SCHED_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*SW-1:0] req_data;
    logic [SW-1:0]   tree_in;
    logic [W-1:0]    tree_out;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_data;
    logic [1:0]      res_id;

    logic [N-1:0]    b1_req_valid;
    logic [N-1:0]    b1_req_ready;
    logic [N*SW-1:0] b1_req_data;
    logic [SW-1:0]   b1_tree_in;
    logic [W-1:0]    b1_tree_out;
    logic            b1_res_valid;
    logic            b1_res_ready;
    logic [W-1:0]    b1_res_data;
    logic [1:0]      b1_res_id;

    gf_sum_sched #(.BIT_WIDTH(W), .PARALLELISM(P), .NUM_REQ(N), .BEATS(B)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .tree_in(tree_in), .tree_out(tree_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
    );

    gf_sum_sched #(.BIT_WIDTH(W), .PARALLELISM(P), .NUM_REQ(N), .BEATS(1)) dut_b1 (
        .clk(clk), .rstn(rstn),
        .req_valid(b1_req_valid), .req_ready(b1_req_ready), .req_data(b1_req_data),
        .tree_in(b1_tree_in), .tree_out(b1_tree_out),
        .res_valid(b1_res_valid), .res_ready(b1_res_ready),
        .res_data(b1_res_data), .res_id(b1_res_id)
    );

    always #5 clk = ~clk;

    // Shared XOR-reduction trees (environment side)
    always_comb begin
        tree_out    = '0;
        b1_tree_out = '0;
        for (int i = 0; i < P; i++) begin
            tree_out    = tree_out ^ tree_in[i*W +: W];
            b1_tree_out = b1_tree_out ^ b1_tree_in[i*W +: W];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [SW-1:0] src     [N][$];
    logic [W-1:0]  exp_sum [N][$];
    int            m_ptr;
    logic [N-1:0]  prev_valid;
    bit            prev_busy;
    bit            prev_resv;
    logic [N-1:0]  hold;
    bit            drop_en;
    int            res_mode;

    // Observation logs
    int            res_id_q[$];
    logic [W-1:0]  res_data_q[$];
    int            res_cyc_q[$];
    int            g_act_q[$];
    int            g_exp_q[$];
    int            beat_cyc_q[$];
    int            resv_rise_q[$];

    function automatic logic [W-1:0] beat_sum(input logic [SW-1:0] b);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < P; i++) s = s ^ b[i*W +: W];
        return s;
    endfunction

    function automatic logic [SW-1:0] rnd_beat();
        return SW'({$urandom, $urandom});
    endfunction

    task automatic add_job(input int r, input logic [SW-1:0] b0, input logic [SW-1:0] b1);
        src[r].push_back(b0);
        src[r].push_back(b1);
        exp_sum[r].push_back(beat_sum(b0) ^ beat_sum(b1));
    endtask

    task automatic reset_model();
        for (int r = 0; r < N; r++) begin
            src[r].delete();
            exp_sum[r].delete();
        end
        res_id_q.delete(); res_data_q.delete(); res_cyc_q.delete();
        g_act_q.delete(); g_exp_q.delete(); beat_cyc_q.delete(); resv_rise_q.delete();
        prev_valid = '0; prev_busy = 1'b0; prev_resv = 1'b0;
        hold = '0; drop_en = 1'b0; res_mode = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0; req_data = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        m_ptr = 0;
        reset_model();
    endtask

    // One clock period: drive from the source queues, observe, advance the model
    task automatic cycle();
        logic [N-1:0] hs_vec;
        for (int r = 0; r < N; r++) begin
            if (src[r].size() > 0 && !hold[r] &&
                !(drop_en && req_ready[r] && $urandom_range(0, 2) == 0)) begin
                req_valid[r] = 1'b1;
                req_data[r*SW +: SW] = src[r][0];
            end else begin
                req_valid[r] = 1'b0;
                req_data[r*SW +: SW] = rnd_beat();
            end
        end
        res_ready = (res_mode == 0) ? 1'b1 : (res_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        hs_vec = req_valid & req_ready;
        if (req_ready != '0 && !prev_busy) begin
            int a = -1;
            int e = -1;
            for (int r = 0; r < N; r++) if (req_ready[r]) a = r;
            for (int i = 0; i < N; i++) begin
                int k = (m_ptr + i) % N;
                if (e < 0 && prev_valid[k]) e = k;
            end
            g_act_q.push_back(a);
            g_exp_q.push_back(e);
        end
        if (res_valid && !prev_resv) resv_rise_q.push_back(cyc);
        if (hs_vec != '0) beat_cyc_q.push_back(cyc);
        if (res_valid && res_ready) begin
            res_id_q.push_back(int'(res_id));
            res_data_q.push_back(res_data);
            res_cyc_q.push_back(cyc);
            m_ptr = (int'(res_id) + 1) % N;
        end
        prev_busy  = |req_ready;
        prev_valid = req_valid;
        prev_resv  = res_valid;
        @(posedge clk);
        for (int r = 0; r < N; r++) if (hs_vec[r]) void'(src[r].pop_front());
        #1;
    endtask

    task automatic run_until(input int n_res, input int budget);
        int k = 0;
        while (res_id_q.size() < n_res && k < budget) begin
            cycle();
            k++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = '1; req_data = {rnd_beat(), rnd_beat(), rnd_beat(), rnd_beat()};
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %0h expected 0", req_ready); end
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
        n_tests++; if (tree_in !== '0) begin n_fail++; $display("FAIL reset_tree_in: got %0h expected 0", tree_in); end
        rstn = 1'b1; m_ptr = 0; reset_model();
        req_valid = '0;
        #1;
        n_tests++; if (res_data !== '0 || res_id !== '0) begin n_fail++; $display("FAIL reset_res: got %0h/%0d expected 0/0", res_data, res_id); end
        for (int r = 0; r < N; r++) add_job(r, rnd_beat(), rnd_beat());
        for (int k = 0; k < 10 && beat_cyc_q.size() < 1; k++) cycle();
        n_tests++; if (req_ready === '0) begin n_fail++; $display("FAIL reset_prejob_ready: got %0h expected nonzero", req_ready); end
        // Asynchronous reset in the middle of a job
        rstn = 1'b0;
        #1;
        n_tests++; if (req_ready !== '0 || res_valid !== 1'b0 || tree_in !== '0) begin
            n_fail++; $display("FAIL reset_midjob: got ready=%0h valid=%0b tree=%0h expected 0/0/0", req_ready, res_valid, tree_in);
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1; m_ptr = 0; reset_model();
        for (int r = 0; r < N; r++) add_job(r, rnd_beat(), rnd_beat());
        run_until(N, 60);
        for (int k = 0; k < 4; k++) cycle();
        n_tests++; if (res_id_q.size() != N) begin n_fail++; $display("FAIL reset_result_count: got %0d expected %0d", res_id_q.size(), N); end
        n_tests++; if (g_act_q.size() < 1 || g_act_q[0] != 0) begin n_fail++; $display("FAIL reset_first_grant: got %0d expected 0", (g_act_q.size() > 0) ? g_act_q[0] : -1); end
        for (int i = 0; i < res_id_q.size(); i++) begin
            n_tests++; if (res_id_q[i] != i) begin n_fail++; $display("FAIL reset_id[%0d]: got %0d expected %0d", i, res_id_q[i], i); end
            n_tests++; if (exp_sum[res_id_q[i]].size() == 0 || res_data_q[i] !== exp_sum[res_id_q[i]].pop_front()) begin
                n_fail++; $display("FAIL reset_sum[%0d]: got %0h", i, res_data_q[i]);
            end
        end
    endtask

    task automatic test_single_job();
        int t0;
        reset_model();
        add_job(1, {10'd8, 10'd4, 10'd2, 10'd1}, {10'd0, 10'd0, 10'd0, 10'd3});
        t0 = cyc;
        run_until(1, 20);
        n_tests++; if (res_id_q.size() != 1) begin n_fail++; $display("FAIL single_timeout: got %0d results expected 1", res_id_q.size()); end
        else begin
            n_tests++; if (res_data_q[0] !== 10'h00C) begin n_fail++; $display("FAIL single_data: got %0h expected 00c", res_data_q[0]); end
            n_tests++; if (res_id_q[0] != 1) begin n_fail++; $display("FAIL single_id: got %0d expected 1", res_id_q[0]); end
            n_tests++; if (beat_cyc_q.size() != 2 || beat_cyc_q[0] != t0 + 1) begin
                n_fail++; $display("FAIL single_first_beat: got %0d expected %0d", (beat_cyc_q.size() > 0) ? beat_cyc_q[0] - t0 : -1, 1);
            end
            n_tests++; if (beat_cyc_q.size() != 2 || resv_rise_q.size() != 1 || resv_rise_q[0] != beat_cyc_q[1] + 1 + PIPE) begin
                n_fail++; $display("FAIL single_latency: got %0d expected %0d", (resv_rise_q.size() > 0) ? resv_rise_q[0] - t0 : -1, B + 1 + PIPE);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        do_reset();
        add_job(0, rnd_beat(), rnd_beat());
        add_job(0, rnd_beat(), rnd_beat());
        for (int r = 1; r < N; r++) add_job(r, rnd_beat(), rnd_beat());
        run_until(5, 60);
        n_tests++; if (res_id_q.size() != 5) begin n_fail++; $display("FAIL rr_timeout: got %0d results expected 5", res_id_q.size()); end
        for (int i = 0; i < res_id_q.size() && i < 5; i++) begin
            n_tests++; if (res_id_q[i] != exp_ids[i]) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d expected %0d", i, res_id_q[i], exp_ids[i]); end
            n_tests++; if (exp_sum[res_id_q[i]].size() == 0 || res_data_q[i] !== exp_sum[res_id_q[i]].pop_front()) begin
                n_fail++; $display("FAIL rr_sum[%0d]: got %0h", i, res_data_q[i]);
            end
            if (i > 0) begin
                n_tests++; if (res_cyc_q[i] - res_cyc_q[i-1] != B + 2 + PIPE) begin
                    n_fail++; $display("FAIL rr_period[%0d]: got %0d expected %0d", i, res_cyc_q[i] - res_cyc_q[i-1], B + 2 + PIPE);
                end
            end
        end
        for (int i = 0; i < g_act_q.size(); i++) begin
            n_tests++; if (g_act_q[i] != g_exp_q[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, g_act_q[i], g_exp_q[i]); end
        end
    endtask

    task automatic test_stalls();
        logic [W-1:0] cap_d;
        logic [1:0]   cap_id;
        int           k;
        reset_model();
        add_job(2, rnd_beat(), rnd_beat());
        for (k = 0; k < 10 && beat_cyc_q.size() < 1; k++) cycle();
        hold[2] = 1'b1;
        add_job(0, rnd_beat(), rnd_beat());
        repeat (3) begin
            cycle();
            n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_ready: got %0h expected 4", req_ready); end
        end
        n_tests++; if (beat_cyc_q.size() != 1) begin n_fail++; $display("FAIL stall_beats: got %0d expected 1", beat_cyc_q.size()); end
        hold = '0;
        res_mode = 1;
        for (k = 0; k < 10 && !res_valid; k++) cycle();
        cap_d = res_data; cap_id = res_id;
        n_tests++; if (cap_id !== 2'd2 || exp_sum[2].size() == 0 || cap_d !== exp_sum[2][0]) begin
            n_fail++; $display("FAIL stall_sum: got %0h/%0d expected %0h/2", cap_d, cap_id, (exp_sum[2].size() > 0) ? exp_sum[2][0] : '0);
        end
        repeat (5) begin
            cycle();
            n_tests++; if (res_valid !== 1'b1 || res_data !== cap_d || res_id !== cap_id || req_ready !== '0) begin
                n_fail++; $display("FAIL stall_done_hold: got v=%0b d=%0h id=%0d rdy=%0h expected 1/%0h/%0d/0", res_valid, res_data, res_id, req_ready, cap_d, cap_id);
            end
        end
        res_mode = 0;
        run_until(2, 30);
        n_tests++; if (res_id_q.size() != 2) begin n_fail++; $display("FAIL stall_timeout: got %0d results expected 2", res_id_q.size()); end
        else begin
            n_tests++; if (res_id_q[1] != 0 || exp_sum[0].size() == 0 || res_data_q[1] !== exp_sum[0][0]) begin
                n_fail++; $display("FAIL stall_second: got %0h/%0d expected req0 sum", res_data_q[1], res_id_q[1]);
            end
        end
        for (int i = 0; i < g_act_q.size(); i++) begin
            n_tests++; if (g_act_q[i] != g_exp_q[i]) begin n_fail++; $display("FAIL stall_grant[%0d]: got %0d expected %0d", i, g_act_q[i], g_exp_q[i]); end
        end
    endtask

    task automatic test_symbols();
        int k;
        reset_model();
        add_job(3, {10'h000, 10'h155, 10'h3FF, 10'h3FF}, {10'h000, 10'h000, 10'h000, 10'h2AA});
        run_until(1, 20);
        n_tests++; if (res_id_q.size() != 1 || res_data_q[0] !== 10'h3FF || res_id_q[0] != 3) begin
            n_fail++; $display("FAIL symbols_sum: got %0h/%0d expected 3ff/3", (res_data_q.size() > 0) ? res_data_q[0] : '0, (res_id_q.size() > 0) ? res_id_q[0] : -1);
        end
        // Single-beat instance
        b1_res_ready = 1'b1;
        b1_req_valid = 4'b0001;
        b1_req_data  = {rnd_beat(), rnd_beat(), rnd_beat(), {10'h000, 10'h155, 10'h3FF, 10'h3FF}};
        for (k = 0; k < 10 && !b1_res_valid; k++) begin
            @(posedge clk);
            #1;
            if (b1_req_ready[0]) begin
                @(posedge clk);
                #1 b1_req_valid = '0;
            end
        end
        n_tests++; if (b1_res_valid !== 1'b1 || b1_res_data !== 10'h155 || b1_res_id !== 2'd0) begin
            n_fail++; $display("FAIL beats1_sum: got v=%0b %0h/%0d expected 1/155/0", b1_res_valid, b1_res_data, b1_res_id);
        end
        b1_req_valid = '0;
        @(posedge clk);
        #1;
        n_tests++; if (b1_res_valid !== 1'b0) begin n_fail++; $display("FAIL beats1_release: got %0b expected 0", b1_res_valid); end
    endtask

    task automatic test_random();
        int njobs = 24;
        reset_model();
        drop_en = 1'b1;
        res_mode = 2;
        for (int j = 0; j < njobs; j++) add_job($urandom_range(0, N - 1), rnd_beat(), rnd_beat());
        run_until(njobs, 2000);
        n_tests++; if (res_id_q.size() != njobs) begin n_fail++; $display("FAIL random_timeout: got %0d results expected %0d", res_id_q.size(), njobs); end
        for (int i = 0; i < res_id_q.size(); i++) begin
            n_tests++; if (exp_sum[res_id_q[i]].size() == 0 || res_data_q[i] !== exp_sum[res_id_q[i]].pop_front()) begin
                n_fail++; $display("FAIL random_sum[%0d]: got %0h id %0d", i, res_data_q[i], res_id_q[i]);
            end
        end
        for (int i = 0; i < g_act_q.size(); i++) begin
            n_tests++; if (g_act_q[i] != g_exp_q[i]) begin n_fail++; $display("FAIL random_grant[%0d]: got %0d expected %0d", i, g_act_q[i], g_exp_q[i]); end
        end
        drop_en = 1'b0;
        res_mode = 0;
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = '0; req_data = '0; res_ready = 1'b0;
        b1_req_valid = '0; b1_req_data = '0; b1_res_ready = 1'b0;
        m_ptr = 0;
        reset_model();
        test_reset();
        test_single_job();
        test_round_robin();
        test_stalls();
        test_symbols();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
